lru_set_controller: RTL

Sequencer and state store for 8-way true-LRU replacement across all sets of the cache. Holds one 8×3-bit age vector per set, accepts one access report per transaction over a valid/ready handshake, and performs the age read-modify-write. Returns the victim way as a one-hot vector and re-initializes every set after reset or flush. Sits between the cache tag/hit logic and the line-fill path.

---
 rtl/lru_set_controller.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/lru_set_controller.sv
// lru_set_controller
//
// 8-way true-LRU replacement sequencer and age store for every set of the
// cache. Each set holds eight 3-bit ages (111 = MRU, 000 = LRU) that always
// form a permutation of 0..7. One access report is accepted per transaction
// over a valid/ready handshake, then the set's ages are read, updated and
// written back. The response carries the one-hot victim way, which is the way
// whose age was 000 before the update.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous, active-low reset
//   i_flush         level request to re-initialize every set (sampled in IDLE)
//   i_req_valid     access report valid
//   o_req_ready     controller can accept a report
//   i_req_set       set index of the report
//   i_req_hit       1 = hit, 0 = miss/fill
//   i_hit_way_8     one-hot hit way (ignored on miss)
//   o_resp_valid    single-cycle pulse, response fields valid
//   o_resp_set      set of the completed transaction
//   o_victim_way_8  one-hot way whose pre-update age was 000
//   o_resp_err      hit reported with a non-one-hot way
//   o_init_done     all sets initialized
//   o_hit_cnt       saturating hit counter      (LRU_STATS_EN only)
//   o_miss_cnt      saturating miss/err counter (LRU_STATS_EN only)
//
// Build option: define LRU_STATS_EN to add the hit/miss counters and ports.

module lru_set_controller #(
  parameter int SETS  = 16,
  parameter int SET_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [SET_W-1:0] i_req_set,
  input  logic             i_req_hit,
  input  logic [7:0]       i_hit_way_8,
  output logic             o_resp_valid,
  output logic [SET_W-1:0] o_resp_set,
  output logic [7:0]       o_victim_way_8,
  output logic             o_resp_err,
  output logic             o_init_done
`ifdef LRU_STATS_EN
  ,
  output logic [15:0]      o_hit_cnt,
  output logic [15:0]      o_miss_cnt
`endif
);

  // Identity permutation: way k holds age k.
  function automatic logic [23:0] ident_ages();
    logic [23:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      v[3*k +: 3] = 3'(k);
    end
    return v;
  endfunction

`ifdef LRU_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction
`endif

  localparam logic [23:0]      IDENT    = ident_ages();
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETS - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_READ,
    S_UPDATE
  } state_e;

  state_e           state_q, state_d;
  logic [SET_W-1:0] init_idx_q, init_idx_d;

  logic             resp_valid_q, resp_valid_d;
  logic [SET_W-1:0] resp_set_q, resp_set_d;
  logic [7:0]       victim_q, victim_d;
  logic             resp_err_q, resp_err_d;

  // Age store and latched request: data only, never reset.
  logic [23:0]      mem_q [SETS];
  logic [23:0]      rd_q;
  logic [SET_W-1:0] req_set_q;
  logic             req_hit_q;
  logic [7:0]       req_way_q;

  logic             handshake;
  logic             way_onehot;
  logic             hit_ok;
  logic [7:0][2:0]  age_old;
  logic [7:0][2:0]  age_new;
  logic [2:0]       hit_age;
  logic [7:0]       victim_w;

  logic             wr_en;
  logic [SET_W-1:0] wr_addr;
  logic [23:0]      wr_data;

  assign o_req_ready = (state_q == S_IDLE) & ~i_flush;
  assign o_init_done = (state_q != S_INIT);
  assign handshake   = i_req_valid & o_req_ready;

  assign o_resp_valid   = resp_valid_q;
  assign o_resp_set     = resp_set_q;
  assign o_victim_way_8 = victim_q;
  assign o_resp_err     = resp_err_q;

  // A non-one-hot hit is treated exactly like a miss.
  assign way_onehot = (req_way_q != 8'd0) && ((req_way_q & (req_way_q - 8'd1)) == 8'd0);
  assign hit_ok     = req_hit_q & way_onehot;
  assign age_old    = rd_q;

  always_comb begin
    hit_age  = '0;
    victim_w = '0;
    age_new  = age_old;
    for (int k = 0; k < 8; k++) begin
      if (req_way_q[k]) hit_age = hit_age | age_old[k];
      victim_w[k] = (age_old[k] == 3'd0);
    end
    for (int k = 0; k < 8; k++) begin
      if (hit_ok) begin
        if (req_way_q[k]) begin
          age_new[k] = 3'd7;
        end else if (age_old[k] > hit_age) begin
          age_new[k] = age_old[k] - 3'd1;
        end
      end else begin
        age_new[k] = victim_w[k] ? 3'd7 : age_old[k] - 3'd1;
      end
    end
  end

  // Single write port shared by the init walk and the UPDATE write-back.
  assign wr_en   = (state_q == S_INIT) | (state_q == S_UPDATE);
  assign wr_addr = (state_q == S_INIT) ? init_idx_q : req_set_q;
  assign wr_data = (state_q == S_INIT) ? IDENT : age_new;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (handshake) begin
      rd_q      <= mem_q[i_req_set];
      req_set_q <= i_req_set;
      req_hit_q <= i_req_hit;
      req_way_q <= i_hit_way_8;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    case (state_q)
      S_INIT: begin
        init_idx_d = init_idx_q + SET_W'(1);
        if (init_idx_q == LAST_SET) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (i_flush) begin
          state_d    = S_INIT;
          init_idx_d = '0;
        end else if (i_req_valid) begin
          state_d = S_READ;
        end
      end
      S_READ:   state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_INIT;
    endcase
  end

  always_comb begin
    resp_valid_d = (state_q == S_UPDATE);
    resp_set_d   = resp_set_q;
    victim_d     = victim_q;
    resp_err_d   = resp_err_q;
    if (state_q == S_UPDATE) begin
      resp_set_d = req_set_q;
      victim_d   = victim_w;
      resp_err_d = req_hit_q & ~way_onehot;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_INIT;
      init_idx_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_set_q   <= '0;
      victim_q     <= 8'h00;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      resp_valid_q <= resp_valid_d;
      resp_set_q   <= resp_set_d;
      victim_q     <= victim_d;
      resp_err_q   <= resp_err_d;
    end
  end

`ifdef LRU_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state_q == S_IDLE) && i_flush) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (state_q == S_UPDATE) begin
      if (hit_ok) hit_cnt_d  = sat_inc(hit_cnt_q);
      else        miss_cnt_d = sat_inc(miss_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign o_hit_cnt  = hit_cnt_q;
  assign o_miss_cnt = miss_cnt_q;
`endif

endmodule
